// File: rtl/mux2_stream_arb_pkg.sv
// rtl/mux2_stream_arb_pkg.sv - shared state encodings and helpers for the two-input packet arbiter
package mux2_stream_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } arb_state_t;

   // Last-served source after reset; 1 makes source 0 win the first contention.
   localparam logic PRIO_RESET = 1'b1;

   function automatic arb_state_t lock_of(input logic src);
      return src ? ST_LOCK1 : ST_LOCK0;
   endfunction

endpackage

// File: rtl/mux2_signal.sv
// rtl/mux2_signal.sv - two-way data multiplexer, S selects I1 when high
module mux2_signal #(
   parameter int C_WIDTH = 8
) (
   input  logic [C_WIDTH-1:0] I0,
   input  logic [C_WIDTH-1:0] I1,
   input  logic               S,
   output logic [C_WIDTH-1:0] O
);

   assign O = S ? I1 : I0;

endmodule

// File: rtl/mux2_stream_arb.sv
// rtl/mux2_stream_arb.sv - packet-locked round-robin arbiter of two streams; MUX2_ARB_STATS_EN adds packet counters
module mux2_stream_arb
   import mux2_stream_arb_pkg::*;
#(
   parameter int C_WIDTH = 8,
   parameter int C_CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [C_WIDTH-1:0] i0_data,
   input  logic               i0_valid,
   input  logic               i0_last,
   output logic               i0_ready,
   input  logic [C_WIDTH-1:0] i1_data,
   input  logic               i1_valid,
   input  logic               i1_last,
   output logic               i1_ready,
   output logic [C_WIDTH-1:0] o_data,
   output logic               o_valid,
   output logic               o_last,
   input  logic               o_ready,
   output logic               o_src,
   output logic [C_CNT_W-1:0] cnt0,
   output logic [C_CNT_W-1:0] cnt1
);

   arb_state_t         state;
   arb_state_t         state_nxt;
   logic               prio;
   logic               sel;
   logic               out_free;
   logic               accept;
   logic               acc_last;
   logic [C_WIDTH-1:0] mux_o;

   mux2_signal #(
      .C_WIDTH (C_WIDTH)
   ) u_mux (
      .I0 (i0_data),
      .I1 (i1_data),
      .S  (sel),
      .O  (mux_o)
   );

   // Ready is a function of the output register only, never of the requester's valid.
   always_comb begin
      state_nxt = state;
      sel       = 1'b0;
      i0_ready  = 1'b0;
      i1_ready  = 1'b0;
      accept    = 1'b0;
      acc_last  = 1'b0;
      out_free  = !o_valid || o_ready;
      case (state)
         ST_IDLE: begin
            if (i0_valid && i1_valid)
               state_nxt = lock_of(!prio);
            else if (i0_valid)
               state_nxt = ST_LOCK0;
            else if (i1_valid)
               state_nxt = ST_LOCK1;
         end
         ST_LOCK0: begin
            sel      = 1'b0;
            i0_ready = out_free;
            accept   = i0_valid && out_free;
            acc_last = i0_last;
            if (accept && i0_last)
               state_nxt = ST_IDLE;
         end
         ST_LOCK1: begin
            sel      = 1'b1;
            i1_ready = out_free;
            accept   = i1_valid && out_free;
            acc_last = i1_last;
            if (accept && i1_last)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         prio    <= PRIO_RESET;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_last  <= 1'b0;
         o_src   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            o_data  <= mux_o;
            o_last  <= acc_last;
            o_src   <= sel;
            o_valid <= 1'b1;
            if (acc_last)
               prio <= sel;
         end else if (o_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

`ifdef MUX2_ARB_STATS_EN
   localparam logic [C_CNT_W-1:0] CNT_MAX = '1;
   localparam logic [C_CNT_W-1:0] CNT_ONE = {{(C_CNT_W-1){1'b0}}, 1'b1};

   // Counts completed packets, holding at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (accept && acc_last) begin
         if (!sel && cnt0 != CNT_MAX)
            cnt0 <= cnt0 + CNT_ONE;
         if (sel && cnt1 != CNT_MAX)
            cnt1 <= cnt1 + CNT_ONE;
      end
   end
`else
   assign cnt0 = '0;
   assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_mux2_stream_arb.sv
// tb/tb_mux2_stream_arb.sv - directed self-checking bench for mux2_stream_arb
module tb_mux2_stream_arb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] i0_data, i1_data, o_data;
   logic       i0_valid, i0_last, i0_ready;
   logic       i1_valid, i1_last, i1_ready;
   logic       o_valid, o_last, o_ready, o_src;
   logic [1:0] cnt0, cnt1;

   typedef struct {
      int         cyc;
      logic       src;
      logic       last;
      logic [7:0] data;
   } beat_t;

   beat_t      got[$];
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic       gate0, gate1;
   int         cyc;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   mux2_stream_arb #(
      .C_WIDTH (8),
      .C_CNT_W (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i0_data  (i0_data),
      .i0_valid (i0_valid),
      .i0_last  (i0_last),
      .i0_ready (i0_ready),
      .i1_data  (i1_data),
      .i1_valid (i1_valid),
      .i1_last  (i1_last),
      .i1_ready (i1_ready),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .o_last   (o_last),
      .o_ready  (o_ready),
      .o_src    (o_src),
      .cnt0     (cnt0),
      .cnt1     (cnt1)
   );

   task automatic drive_inputs();
      i0_valid = gate0 && (q0.size() > 0);
      i0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      i0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
      i1_valid = gate1 && (q1.size() > 0);
      i1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      i1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
   endtask

   task automatic cycle();
      logic  hs0, hs1;
      beat_t b;
      hs0 = i0_valid && i0_ready;
      hs1 = i1_valid && i1_ready;
      if (rst_n && o_valid && o_ready) begin
         b.cyc  = cyc;
         b.src  = o_src;
         b.last = o_last;
         b.data = o_data;
         got.push_back(b);
      end
      @(posedge clk);
      #1;
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
      cyc++;
      drive_inputs();
   endtask

   task automatic start();
      rst_n   = 1'b0;
      gate0   = 1'b0;
      gate1   = 1'b0;
      o_ready = 1'b1;
      q0.delete();
      q1.delete();
      got.delete();
      drive_inputs();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      o_ready  = 1'b1;
      i0_valid = 1'b1;
      i1_valid = 1'b1;
      i0_data  = 8'h5a;
      i1_data  = 8'ha5;
      i0_last  = 1'b0;
      i1_last  = 1'b0;
      #1;
      checks++;
      if ({o_valid, o_last, o_src, o_data} !== 11'h0) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b last=%b src=%b data=%h want all 0", o_valid, o_last, o_src, o_data);
      end
      checks++;
      if ({i0_ready, i1_ready} !== 2'b00) begin
         failures++;
         $display("FAIL reset_ready: got %b%b want 00", i0_ready, i1_ready);
      end
      checks++;
      if ({cnt0, cnt1} !== 4'h0) begin
         failures++;
         $display("FAIL reset_counters: got cnt0=%0d cnt1=%0d want 0 0", cnt0, cnt1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_source();
      logic [9:0] ev[3] = '{{1'b0, 1'b0, 8'h11}, {1'b0, 1'b0, 8'h22}, {1'b0, 1'b1, 8'h33}};
      int         ec[3] = '{2, 3, 4};
      start();
      q0 = '{9'h011, 9'h022, 9'h133};
      gate0 = 1'b1;
      drive_inputs();
      repeat (8) begin
         #1;
         checks++;
         if (i1_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_i1_ready cyc%0d: got %b want 0", cyc, i1_ready);
         end
         if (cyc == 5) begin
            checks++;
            if (o_valid !== 1'b0) begin
               failures++;
               $display("FAIL single_drain: got o_valid=%b want 0", o_valid);
            end
         end
         cycle();
      end
      checks++;
      if (got.size() != 3) begin
         failures++;
         $display("FAIL single_count: got %0d beats want 3", got.size());
      end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         checks++;
         if ({got[i].src, got[i].last, got[i].data} !== ev[i] || got[i].cyc != ec[i]) begin
            failures++;
            $display("FAIL single_beat%0d: got src/last/data=%h cyc=%0d want %h cyc=%0d",
                     i, {got[i].src, got[i].last, got[i].data}, got[i].cyc, ev[i], ec[i]);
         end
      end
   endtask

   task automatic test_contention();
      logic [9:0] ev[8] = '{{1'b0, 1'b0, 8'ha0}, {1'b0, 1'b1, 8'ha1}, {1'b1, 1'b0, 8'hb0}, {1'b1, 1'b1, 8'hb1},
                            {1'b0, 1'b0, 8'ha2}, {1'b0, 1'b1, 8'ha3}, {1'b1, 1'b0, 8'hb2}, {1'b1, 1'b1, 8'hb3}};
      int         ec[8] = '{2, 3, 5, 6, 8, 9, 11, 12};
      start();
      q0 = '{9'h0a0, 9'h1a1, 9'h0a2, 9'h1a3};
      q1 = '{9'h0b0, 9'h1b1, 9'h0b2, 9'h1b3};
      gate0 = 1'b1;
      gate1 = 1'b1;
      drive_inputs();
      repeat (16) begin
         #1;
         cycle();
      end
      checks++;
      if (got.size() != 8) begin
         failures++;
         $display("FAIL contention_count: got %0d beats want 8", got.size());
      end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         checks++;
         if ({got[i].src, got[i].last, got[i].data} !== ev[i] || got[i].cyc != ec[i]) begin
            failures++;
            $display("FAIL contention_beat%0d: got src/last/data=%h cyc=%0d want %h cyc=%0d",
                     i, {got[i].src, got[i].last, got[i].data}, got[i].cyc, ev[i], ec[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [9:0] ev[4] = '{{1'b0, 1'b0, 8'h41}, {1'b0, 1'b0, 8'h42}, {1'b0, 1'b0, 8'h43}, {1'b0, 1'b1, 8'h44}};
      int         ec[4] = '{2, 6, 7, 8};
      start();
      q0 = '{9'h041, 9'h042, 9'h043, 9'h144};
      gate0 = 1'b1;
      drive_inputs();
      repeat (12) begin
         o_ready = !(cyc >= 3 && cyc <= 5);
         #1;
         if (cyc >= 3 && cyc <= 5) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== 8'h42 || i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
               failures++;
               $display("FAIL backpressure_hold cyc%0d: got valid=%b data=%h rdy=%b%b want 1 42 00",
                        cyc, o_valid, o_data, i0_ready, i1_ready);
            end
         end
         cycle();
      end
      checks++;
      if (got.size() != 4) begin
         failures++;
         $display("FAIL backpressure_count: got %0d beats want 4", got.size());
      end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         checks++;
         if ({got[i].src, got[i].last, got[i].data} !== ev[i] || got[i].cyc != ec[i]) begin
            failures++;
            $display("FAIL backpressure_beat%0d: got src/last/data=%h cyc=%0d want %h cyc=%0d",
                     i, {got[i].src, got[i].last, got[i].data}, got[i].cyc, ev[i], ec[i]);
         end
      end
   endtask

   task automatic test_gap();
      logic [9:0] ev[4] = '{{1'b1, 1'b0, 8'h51}, {1'b1, 1'b0, 8'h52}, {1'b1, 1'b1, 8'h53}, {1'b0, 1'b1, 8'h61}};
      int         ec[4] = '{2, 3, 6, 8};
      start();
      q1 = '{9'h051, 9'h052, 9'h153};
      q0 = '{9'h161};
      gate0 = 1'b0;
      gate1 = 1'b1;
      drive_inputs();
      repeat (12) begin
         #1;
         if (cyc >= 2 && cyc <= 6) begin
            checks++;
            if (i0_ready !== 1'b0) begin
               failures++;
               $display("FAIL gap_i0_ready cyc%0d: got %b want 0", cyc, i0_ready);
            end
         end
         gate0 = (cyc + 1) >= 2;
         gate1 = !((cyc + 1) == 3 || (cyc + 1) == 4);
         cycle();
      end
      checks++;
      if (got.size() != 4) begin
         failures++;
         $display("FAIL gap_count: got %0d beats want 4", got.size());
      end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         checks++;
         if ({got[i].src, got[i].last, got[i].data} !== ev[i] || got[i].cyc != ec[i]) begin
            failures++;
            $display("FAIL gap_beat%0d: got src/last/data=%h cyc=%0d want %h cyc=%0d",
                     i, {got[i].src, got[i].last, got[i].data}, got[i].cyc, ev[i], ec[i]);
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [9:0] ev[5] = '{{1'b0, 1'b1, 8'h81}, {1'b1, 1'b0, 8'h71}, {1'b0, 1'b1, 8'h91},
                            {1'b1, 1'b0, 8'h74}, {1'b1, 1'b1, 8'h75}};
      int         ec[5] = '{2, 6, 10, 12, 13};
      start();
      q0 = '{9'h181};
      gate0 = 1'b1;
      gate1 = 1'b1;
      drive_inputs();
      repeat (16) begin
         if (cyc == 4) begin
            q1 = '{9'h071, 9'h072, 9'h173};
            drive_inputs();
         end
         if (cyc == 7) rst_n = 1'b0;
         if (cyc == 8) begin
            rst_n = 1'b1;
            q0 = '{9'h191};
            q1 = '{9'h074, 9'h175};
            drive_inputs();
         end
         #1;
         if (cyc == 7) begin
            checks++;
            if ({o_valid, o_last, o_src, o_data} !== 11'h0 || {i0_ready, i1_ready} !== 2'b00) begin
               failures++;
               $display("FAIL midreset_outputs: got valid=%b last=%b src=%b data=%h rdy=%b%b want all 0",
                        o_valid, o_last, o_src, o_data, i0_ready, i1_ready);
            end
            q0.delete();
            q1.delete();
            drive_inputs();
         end
         if (cyc == 8) begin
            checks++;
            if ({i0_ready, i1_ready} !== 2'b00) begin
               failures++;
               $display("FAIL midreset_idle: got rdy=%b%b want 00", i0_ready, i1_ready);
            end
         end
         cycle();
      end
      checks++;
      if (got.size() != 5) begin
         failures++;
         $display("FAIL midreset_count: got %0d beats want 5", got.size());
      end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         checks++;
         if ({got[i].src, got[i].last, got[i].data} !== ev[i] || got[i].cyc != ec[i]) begin
            failures++;
            $display("FAIL midreset_beat%0d: got src/last/data=%h cyc=%0d want %h cyc=%0d",
                     i, {got[i].src, got[i].last, got[i].data}, got[i].cyc, ev[i], ec[i]);
         end
      end
   endtask

   task automatic test_stats();
      logic [1:0] exp_mid, exp_end;
`ifdef MUX2_ARB_STATS_EN
      exp_mid = 2'd2;
      exp_end = 2'd3;
`else
      exp_mid = 2'd0;
      exp_end = 2'd0;
`endif
      start();
      q0 = '{9'h1c0, 9'h1c1, 9'h1c2, 9'h1c3, 9'h1c4};
      gate0 = 1'b1;
      drive_inputs();
      repeat (14) begin
         #1;
         if (cyc == 5) begin
            checks++;
            if (cnt0 !== exp_mid) begin
               failures++;
               $display("FAIL stats_mid_cnt0: got %0d want %0d", cnt0, exp_mid);
            end
         end
         cycle();
      end
      checks++;
      if (got.size() != 5) begin
         failures++;
         $display("FAIL stats_count: got %0d beats want 5", got.size());
      end
      checks++;
      if (cnt0 !== exp_end || cnt1 !== 2'd0) begin
         failures++;
         $display("FAIL stats_final: got cnt0=%0d cnt1=%0d want %0d 0", cnt0, cnt1, exp_end);
      end
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_contention();
      test_backpressure();
      test_gap();
      test_reset_mid_packet();
      test_stats();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
